// File: rtl/datapath_sequencer.sv
// ---------------------------------------------------------------------------
// datapath_sequencer
//
// Multi-cycle controller for the 8-bit datapath (PC, instruction memory,
// 4x8 register file, ALU, data memory). Each instruction walks through
// FETCH / DECODE / EXEC / [MEM] / [WB]. The block drives the PC advance,
// IR load, register write, memory strobes and mux selects. It also provides
// run / single-step control and hands the data memory port to an external
// loader/debug master between instructions.
//
// Optional feature: define SEQ_BREAKPOINT_EN to add a PC breakpoint unit
// (ports pc_i, bp_addr_i, bp_valid_i, bp_hit_o).
//
// Parameters
//   MEM_WAIT  extra cycles spent in MEM for slow data memory (0..7)
//   RET_W     width of the retired-instruction counter
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   run_i        level, free-run instructions while high
//   step_i       one-cycle pulse, run exactly one instruction while not running
//   opcode_i     instruction[7:6], valid from DECODE onward
//   pc_en_o      one-cycle PC advance pulse at instruction end
//   ir_load_o    latch instruction register
//   reg_wr_en_o  register file write enable
//   mem_rd_o     data memory read strobe
//   mem_wr_o     data memory write strobe
//   alu_src_o    ALU B operand: 0 register, 1 zero-extended immediate
//   wb_src_o     write-back source: 0 ALU result, 1 memory data
//   mem_sel_o    data memory port owner: 0 core, 1 external
//   ext_req_i    external master requests the memory port (level)
//   ext_done_i   external master releases the port
//   ext_gnt_o    grant to the external master
//   busy_o       high in every state except IDLE
//   state_o      current state encoding
//   retired_o    count of completed instructions (wraps)
//   pc_i         (breakpoint) current PC value
//   bp_addr_i    (breakpoint) breakpoint address
//   bp_valid_i   (breakpoint) breakpoint armed
//   bp_hit_o     (breakpoint) run stopped at the breakpoint
// ---------------------------------------------------------------------------
module datapath_sequencer #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned RET_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic             step_i,
    input  logic [1:0]       opcode_i,
    output logic             pc_en_o,
    output logic             ir_load_o,
    output logic             reg_wr_en_o,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic             alu_src_o,
    output logic             wb_src_o,
    output logic             mem_sel_o,
    input  logic             ext_req_i,
    input  logic             ext_done_i,
    output logic             ext_gnt_o,
    output logic             busy_o,
    output logic [2:0]       state_o,
    output logic [RET_W-1:0] retired_o
`ifdef SEQ_BREAKPOINT_EN
    ,
    input  logic [7:0]       pc_i,
    input  logic [7:0]       bp_addr_i,
    input  logic             bp_valid_i,
    output logic             bp_hit_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_EXT    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_RTYPE = 2'b00,
        OP_ITYPE = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } opcode_t;

    typedef struct packed {
        logic pc_en;
        logic ir_load;
        logic reg_wr_en;
        logic mem_rd;
        logic mem_wr;
        logic alu_src;
        logic wb_src;
        logic mem_sel;
        logic ext_gnt;
        logic busy;
    } ctrl_t;

    // Last MEM cycle index; MEM lasts MEM_WAIT+1 cycles.
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t           state_q, state_d;
    opcode_t          op_q, op_d;
    logic [2:0]       wait_q, wait_d;
    ctrl_t            ctrl_q;
    logic             step_pending_q;
    logic             step_take;
    logic [RET_W-1:0] retired_q;
    logic             run_eff;
    logic             take_boundary;
    state_t           boundary_state;

`ifdef SEQ_BREAKPOINT_EN
    logic bp_hit_q;
    logic bp_match;
    logic boundary_bp;

    assign bp_match = bp_valid_i && (pc_i == bp_addr_i);
    // A pending breakpoint hit masks run_i until run_i drops or a step arrives.
    assign run_eff  = run_i && !bp_hit_q;
    assign bp_hit_o = bp_hit_q;
`else
    assign run_eff  = run_i;
`endif

    // Instruction-boundary decision: external master first, then free-run.
    // Shared by IDLE and by the last cycle of every instruction.
    always_comb begin
        // NOTE: every variable gets a default before the branches so no latch is inferred.
        boundary_state = ST_IDLE;
`ifdef SEQ_BREAKPOINT_EN
        boundary_bp    = 1'b0;
`endif
        if (ext_req_i) begin
            boundary_state = ST_EXT;
        end else if (run_eff) begin
`ifdef SEQ_BREAKPOINT_EN
            if (bp_match) boundary_bp = 1'b1;
            else          boundary_state = ST_FETCH;
`else
            boundary_state = ST_FETCH;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wait_d        = 3'd0;
        step_take     = 1'b0;
        take_boundary = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A pending step bypasses the breakpoint; external request still wins.
                if (!ext_req_i && step_pending_q) begin
                    state_d   = ST_FETCH;
                    step_take = 1'b1;
                end else begin
                    take_boundary = 1'b1;
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                op_d    = opcode_t'(opcode_i);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (op_q == OP_LOAD || op_q == OP_STORE) state_d = ST_MEM;
                else                                     state_d = ST_WB;
            end
            ST_MEM: begin
                if (wait_q == WAIT_LAST) begin
                    if (op_q == OP_LOAD) state_d = ST_WB;
                    else                 take_boundary = 1'b1;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_WB:  take_boundary = 1'b1;
            ST_EXT: if (ext_done_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;   // unused encoding 7
        endcase
        if (take_boundary) state_d = boundary_state;
    end

    // Control word for a given state; registered so outputs never see inputs.
    function automatic ctrl_t decode_ctrl(input state_t s, input opcode_t op,
                                          input logic [2:0] w);
        ctrl_t c;
        c      = '0;
        c.busy = (s != ST_IDLE);
        case (s)
            ST_FETCH: c.ir_load = 1'b1;
            ST_EXEC:  c.alu_src = (op != OP_RTYPE);
            ST_MEM: begin
                c.alu_src = 1'b1;
                c.mem_rd  = (op == OP_LOAD);
                c.mem_wr  = (op == OP_STORE);
                c.pc_en   = (op == OP_STORE) && (w == WAIT_LAST);
            end
            ST_WB: begin
                c.reg_wr_en = 1'b1;
                c.pc_en     = 1'b1;
                c.wb_src    = (op == OP_LOAD);
                c.alu_src   = (op != OP_RTYPE);
            end
            ST_EXT: begin
                c.ext_gnt = 1'b1;
                c.mem_sel = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: every flop here is control state and must start known, so all are in the reset branch.
        if (!reset) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_RTYPE;
            wait_q         <= 3'd0;
            ctrl_q         <= '0;
            step_pending_q <= 1'b0;
            retired_q      <= '0;
`ifdef SEQ_BREAKPOINT_EN
            bp_hit_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            ctrl_q  <= decode_ctrl(state_d, op_d, wait_d);

            // A new step has priority over consumption so back-to-back steps are not lost.
            if (step_i && !run_eff) step_pending_q <= 1'b1;
            else if (step_take)     step_pending_q <= 1'b0;

            // Count on the cycle the PC-advance pulse is visible.
            if (ctrl_q.pc_en) retired_q <= retired_q + RET_W'(1);

`ifdef SEQ_BREAKPOINT_EN
            if (take_boundary && boundary_bp) bp_hit_q <= 1'b1;
            else if (!run_i || step_i)        bp_hit_q <= 1'b0;
`endif
        end
    end

    assign pc_en_o     = ctrl_q.pc_en;
    assign ir_load_o   = ctrl_q.ir_load;
    assign reg_wr_en_o = ctrl_q.reg_wr_en;
    assign mem_rd_o    = ctrl_q.mem_rd;
    assign mem_wr_o    = ctrl_q.mem_wr;
    assign alu_src_o   = ctrl_q.alu_src;
    assign wb_src_o    = ctrl_q.wb_src;
    assign mem_sel_o   = ctrl_q.mem_sel;
    assign ext_gnt_o   = ctrl_q.ext_gnt;
    assign busy_o      = ctrl_q.busy;
    assign state_o     = state_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// ---------------------------------------------------------------------------
// tb_datapath_sequencer
//
// Directed bench for datapath_sequencer. A main instance (MEM_WAIT=2,
// RET_W=16) and a narrow-counter instance (RET_W=3) share all stimulus so
// the counter wrap is reached in a handful of instructions.
// Breakpoint scenarios are compiled in with SEQ_BREAKPOINT_EN.
// ---------------------------------------------------------------------------
module tb_datapath_sequencer;

    localparam int unsigned MW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_i, step_i, ext_req_i, ext_done_i;
    logic [1:0]  opcode_i;

    logic        pc_en_o, ir_load_o, reg_wr_en_o, mem_rd_o, mem_wr_o;
    logic        alu_src_o, wb_src_o, mem_sel_o, ext_gnt_o, busy_o;
    logic [2:0]  state_o;
    logic [15:0] retired_o;

    logic        s_pc_en, s_ir_load, s_reg_wr, s_mem_rd, s_mem_wr;
    logic        s_alu_src, s_wb_src, s_mem_sel, s_ext_gnt, s_busy;
    logic [2:0]  s_state;
    logic [2:0]  s_retired;

`ifdef SEQ_BREAKPOINT_EN
    logic [7:0]  pc_i, bp_addr_i;
    logic        bp_valid_i, bp_hit_o, s_bp_hit;
`endif

    datapath_sequencer #(.MEM_WAIT(MW), .RET_W(16)) dut (
        .clk(clk), .reset(reset), .run_i(run_i), .step_i(step_i), .opcode_i(opcode_i),
        .pc_en_o(pc_en_o), .ir_load_o(ir_load_o), .reg_wr_en_o(reg_wr_en_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .alu_src_o(alu_src_o),
        .wb_src_o(wb_src_o), .mem_sel_o(mem_sel_o), .ext_req_i(ext_req_i),
        .ext_done_i(ext_done_i), .ext_gnt_o(ext_gnt_o), .busy_o(busy_o),
        .state_o(state_o), .retired_o(retired_o)
`ifdef SEQ_BREAKPOINT_EN
        , .pc_i(pc_i), .bp_addr_i(bp_addr_i), .bp_valid_i(bp_valid_i), .bp_hit_o(bp_hit_o)
`endif
    );

    datapath_sequencer #(.MEM_WAIT(MW), .RET_W(3)) dut_small (
        .clk(clk), .reset(reset), .run_i(run_i), .step_i(step_i), .opcode_i(opcode_i),
        .pc_en_o(s_pc_en), .ir_load_o(s_ir_load), .reg_wr_en_o(s_reg_wr),
        .mem_rd_o(s_mem_rd), .mem_wr_o(s_mem_wr), .alu_src_o(s_alu_src),
        .wb_src_o(s_wb_src), .mem_sel_o(s_mem_sel), .ext_req_i(ext_req_i),
        .ext_done_i(ext_done_i), .ext_gnt_o(s_ext_gnt), .busy_o(s_busy),
        .state_o(s_state), .retired_o(s_retired)
`ifdef SEQ_BREAKPOINT_EN
        , .pc_i(pc_i), .bp_addr_i(bp_addr_i), .bp_valid_i(bp_valid_i), .bp_hit_o(s_bp_hit)
`endif
    );

    always #5 clk = ~clk;

    logic [9:0] ctrl_bus, s_ctrl_bus;
    assign ctrl_bus   = {pc_en_o, ir_load_o, reg_wr_en_o, mem_rd_o, mem_wr_o,
                         alu_src_o, wb_src_o, mem_sel_o, ext_gnt_o, busy_o};
    assign s_ctrl_bus = {s_pc_en, s_ir_load, s_reg_wr, s_mem_rd, s_mem_wr,
                         s_alu_src, s_wb_src, s_mem_sel, s_ext_gnt, s_busy};

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ret = 0;

    // Per-cycle history of the strobes, bit j-1 = cycle j of a scenario.
    logic [15:0] h_pc, h_ir, h_rw, h_rd, h_wr, h_alu, h_wb, h_sel, h_gnt, h_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        h_pc = '0; h_ir = '0; h_rw = '0; h_rd = '0; h_wr = '0;
        h_alu = '0; h_wb = '0; h_sel = '0; h_gnt = '0; h_busy = '0;
    endtask

    task automatic record(input int j);
        h_pc[j-1]   = pc_en_o;
        h_ir[j-1]   = ir_load_o;
        h_rw[j-1]   = reg_wr_en_o;
        h_rd[j-1]   = mem_rd_o;
        h_wr[j-1]   = mem_wr_o;
        h_alu[j-1]  = alu_src_o;
        h_wb[j-1]   = wb_src_o;
        h_sel[j-1]  = mem_sel_o;
        h_gnt[j-1]  = ext_gnt_o;
        h_busy[j-1] = busy_o;
    endtask

    // Bounded wait for IDLE; an expired budget shows up as a state mismatch.
    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (state_o != 3'd0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state_o), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        run_i      = 1'b0;
        step_i     = 1'b0;
        ext_req_i  = 1'b0;
        ext_done_i = 1'b0;
        opcode_i   = 2'b00;
`ifdef SEQ_BREAKPOINT_EN
        pc_i       = 8'h00;
        bp_addr_i  = 8'h05;
        bp_valid_i = 1'b0;
`endif

        // ---- reset state ----
        tick(); tick();
        check("rst_ctrl",    32'(ctrl_bus),   32'd0);
        check("rst_ctrl_s",  32'(s_ctrl_bus), 32'd0);
        check("rst_state",   32'(state_o),    32'd0);
        check("rst_retired", 32'(retired_o),  32'd0);
        reset = 1'b1;
        tick(); tick();
        check("idle_hold", 32'(state_o), 32'd0);

        // ---- free run, four R-type ----
        clear_hist();
        opcode_i = 2'b00;
        run_i    = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            record(j);
            if (j == 16) run_i = 1'b0;
        end
        check("run_pc_en",  32'(h_pc),   32'h8888);
        check("run_reg_wr", 32'(h_rw),   32'h8888);
        check("run_ir",     32'(h_ir),   32'h1111);
        check("run_alu",    32'(h_alu),  32'h0000);
        check("run_busy",   32'(h_busy), 32'hFFFF);
        tick();
        exp_ret = 4;
        check("run_idle",    32'(state_o),   32'd0);
        check("run_retired", 32'(retired_o), 32'(exp_ret));

        // ---- single step, load, MEM_WAIT=2 ----
        clear_hist();
        opcode_i = 2'b10;
        step_i   = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j == 1) step_i = 1'b0;
            record(j);
        end
        check("ld_mem_rd", 32'(h_rd),   32'h0070);
        check("ld_wb_src", 32'(h_wb),   32'h0080);
        check("ld_pc_en",  32'(h_pc),   32'h0080);
        check("ld_alu",    32'(h_alu),  32'h00F8);
        check("ld_ir",     32'(h_ir),   32'h0002);
        check("ld_busy",   32'(h_busy), 32'h00FE);
        exp_ret = 5;
        check("ld_idle",    32'(state_o),   32'd0);
        check("ld_retired", 32'(retired_o), 32'(exp_ret));

        // ---- store with external request raised during EXEC ----
        clear_hist();
        opcode_i = 2'b11;
        run_i    = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            tick();
            record(j);
            if (j == 3) begin
                check("st_in_exec", 32'(state_o), 32'd3);
                ext_req_i = 1'b1;
            end
        end
        check("st_mem_wr",  32'(h_wr),  32'h0038);
        check("st_pc_en",   32'(h_pc),  32'h0020);
        check("st_alu",     32'(h_alu), 32'h003C);
        check("st_rw",      32'(h_rw),  32'h0000);
        check("st_gnt",     32'(h_gnt), 32'h0040);
        check("st_mem_sel", 32'(h_sel), 32'h0040);
        check("ext_state",  32'(state_o), 32'd6);
        exp_ret = 6;
        check("st_retired", 32'(retired_o), 32'(exp_ret));
        // Request drops without done: grant must be held.
        ext_req_i = 1'b0;
        tick(); tick();
        check("ext_hold", 32'({state_o, ext_gnt_o, mem_sel_o, busy_o}), 32'({3'd6, 3'b111}));
        ext_done_i = 1'b1;
        tick();
        ext_done_i = 1'b0;
        check("ext_release", 32'({state_o, ext_gnt_o, mem_sel_o, busy_o}), 32'd0);
        tick();
        check("ext_resume", 32'(state_o), 32'd1);
        run_i = 1'b0;
        wait_idle("st2_idle", 20);
        exp_ret = 7;
        check("st2_retired", 32'(retired_o), 32'(exp_ret));

        // ---- step while running is discarded; I-type operand select ----
        clear_hist();
        opcode_i = 2'b01;
        run_i    = 1'b1;
        step_i   = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (j == 1) begin
                step_i = 1'b0;
                run_i  = 1'b0;
            end
            record(j);
        end
        check("it_alu", 32'(h_alu), 32'h000C);
        check("it_rw",  32'(h_rw),  32'h0008);
        check("it_ir",  32'(h_ir),  32'h0001);
        tick(); tick(); tick();
        check("step_discard", 32'(state_o), 32'd0);
        exp_ret = 8;
        check("it_retired", 32'(retired_o), 32'(exp_ret));
        check("wrap",       32'(s_retired), 32'd0);
        check("wrap_state", 32'(s_state),   32'd0);

`ifdef SEQ_BREAKPOINT_EN
        // ---- breakpoint at PC 05 while running ----
        opcode_i   = 2'b00;
        pc_i       = 8'h04;
        bp_addr_i  = 8'h05;
        bp_valid_i = 1'b1;
        run_i      = 1'b1;
        for (int j = 1; j <= 4; j++) tick();
        check("bp_in_wb", 32'(state_o), 32'd5);
        pc_i = 8'h05;
        tick();
        exp_ret = 9;
        check("bp_stop",    32'({state_o, bp_hit_o}), 32'({3'd0, 1'b1}));
        check("bp_retired", 32'(retired_o), 32'(exp_ret));
        tick(); tick();
        check("bp_hold", 32'({state_o, bp_hit_o}), 32'({3'd0, 1'b1}));
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        check("bp_clear", 32'({state_o, bp_hit_o}), 32'd0);
        tick();
        check("bp_step_fetch", 32'(state_o), 32'd1);
        run_i = 1'b0;
        wait_idle("bp_step_idle", 20);
        exp_ret = 10;
        check("bp_step_retired", 32'(retired_o), 32'(exp_ret));
        check("bp_hit_low", 32'(bp_hit_o), 32'd0);
        bp_valid_i = 1'b0;
`endif

        // ---- reset asserted in the middle of WB ----
        opcode_i = 2'b00;
        run_i    = 1'b1;
        for (int j = 1; j <= 4; j++) tick();
        check("pre_rst_wb", 32'({state_o, pc_en_o}), 32'({3'd5, 1'b1}));
        reset = 1'b0;
        #1;
        check("mid_rst_ctrl",    32'(ctrl_bus),  32'd0);
        check("mid_rst_state",   32'(state_o),   32'd0);
        check("mid_rst_retired", 32'(retired_o), 32'd0);
        run_i = 1'b0;
        tick(); tick();
        check("rst_no_pulse", 32'({retired_o, pc_en_o}), 32'd0);
        reset = 1'b1;
        tick(); tick();
        check("post_rst_idle", 32'({state_o, retired_o}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
